// File: rtl/rv32_barrel_pc_unit_pkg.sv
// Shared rv32 types and constants for the barrel-threaded PC unit.
// Opcodes arrive already decoded from execute; only control-transfer ones matter here.
package rv32_barrel_pc_unit_pkg;

  localparam int RV32_XLEN      = 32;
  localparam int RV32_NUM_HARTS = 8;

  typedef logic [RV32_XLEN-1:0] rv32_register_t;
  typedef logic [RV32_XLEN-1:0] rv32_imm_t;
  typedef logic [RV32_XLEN-1:0] rv32_pc_cnt_t;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_ALU   = 4'd1,
    OP_LUI   = 4'd2,
    OP_AUIPC = 4'd3,
    OP_JAL   = 4'd4,
    OP_JALR  = 4'd5,
    OP_BEQ   = 4'd6,
    OP_BNE   = 4'd7,
    OP_BLT   = 4'd8,
    OP_BGE   = 4'd9,
    OP_BLTU  = 4'd10,
    OP_BGEU  = 4'd11,
    OP_LOAD  = 4'd12,
    OP_STORE = 4'd13
  } rv32_opcode_enum_t;

  function automatic logic is_branch(rv32_opcode_enum_t op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) ||
           (op == OP_BGE) || (op == OP_BLTU) || (op == OP_BGEU);
  endfunction

endpackage

// File: rtl/rv32_barrel_pc_unit_target_calc.sv
// Combinational next-PC / link-value computation for one resolved instruction.
// All sums wrap modulo 2^32; the immediate is already a byte offset.
module rv32_target_calc
  import rv32_barrel_pc_unit_pkg::*;
(
  input  rv32_opcode_enum_t opcode_i,
  input  rv32_pc_cnt_t      pc_i,
  input  rv32_register_t    rs1_i,
  input  logic              cond_i,
  input  rv32_imm_t         imm_i,
  output logic              take_o,
  output rv32_pc_cnt_t      target_o,
  output logic              misalign_o,
  output logic              link_o,
  output rv32_pc_cnt_t      link_pc_o
);

  rv32_pc_cnt_t pc_rel;
  rv32_pc_cnt_t rs1_rel;

  assign pc_rel  = pc_i + imm_i;
  assign rs1_rel = rs1_i + imm_i;

  always_comb begin
    take_o    = 1'b0;
    target_o  = pc_rel;
    link_o    = 1'b0;
    link_pc_o = pc_i + 32'd4;
    if (is_branch(opcode_i)) begin
      take_o = cond_i;
    end else begin
      case (opcode_i)
        OP_JAL: begin
          take_o = 1'b1;
          link_o = 1'b1;
        end
        OP_JALR: begin
          take_o   = 1'b1;
          link_o   = 1'b1;
          target_o = {rs1_rel[31:1], 1'b0};
        end
        // AUIPC reuses the link path to carry pc+imm to the register file
        OP_AUIPC: begin
          link_o    = 1'b1;
          link_pc_o = pc_rel;
        end
        default: ;
      endcase
    end
  end

  assign misalign_o = take_o & (|target_o[1:0]);

endmodule

// File: rtl/rv32_barrel_pc_unit.sv
// Per-hart PC file with round-robin fetch selection and execute-stage redirects.
// Fetch and resolve both complete in one cycle; a resolve beats a same-hart fetch increment.
module rv32_barrel_pc_unit
  import rv32_barrel_pc_unit_pkg::*;
#(
  parameter int           NUM_HARTS = RV32_NUM_HARTS,
  parameter logic [31:0]  RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]  TRAP_PC   = 32'h0000_0100,
  localparam int          HART_W    = $clog2(NUM_HARTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_HARTS-1:0] hart_en,
  input  logic                 ex_valid,
  input  logic [HART_W-1:0]    ex_hart,
  input  rv32_opcode_enum_t    ex_opcode,
  input  rv32_pc_cnt_t         ex_pc,
  input  rv32_register_t       ex_rs1,
  input  rv32_register_t       ex_alu_res,
  input  rv32_imm_t            ex_imm,
  output logic                 fetch_valid,
  output logic [HART_W-1:0]    fetch_hart,
  output logic [31:0]          fetch_pc,
  output logic                 wb_save_pc,
  output logic [HART_W-1:0]    wb_hart,
  output logic [31:0]          wb_reg_pc,
  output logic                 redirect,
  output logic                 misalign
);

  rv32_pc_cnt_t        pc_q [NUM_HARTS];
  logic [HART_W-1:0]   ptr_q;

  logic                sel_found_d;
  logic [HART_W-1:0]   sel_hart_d;
  logic [HART_W-1:0]   probe;

  logic                take;
  logic                tgt_misalign;
  logic                link;
  rv32_pc_cnt_t        target;
  rv32_pc_cnt_t        link_pc;
  logic                unused_alu_hi;

  assign unused_alu_hi = ^ex_alu_res[31:1];

  rv32_target_calc u_target_calc (
    .opcode_i   (ex_opcode),
    .pc_i       (ex_pc),
    .rs1_i      (ex_rs1),
    .cond_i     (ex_alu_res[0]),
    .imm_i      (ex_imm),
    .take_o     (take),
    .target_o   (target),
    .misalign_o (tgt_misalign),
    .link_o     (link),
    .link_pc_o  (link_pc)
  );

  // Scan from the pointer upward; HART_W-bit wrap gives the modulo for free
  always_comb begin
    sel_found_d = 1'b0;
    sel_hart_d  = '0;
    probe       = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      probe = ptr_q + HART_W'(i);
      if (!sel_found_d && hart_en[probe]) begin
        sel_found_d = 1'b1;
        sel_hart_d  = probe;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_HARTS; i++) pc_q[i] <= RESET_PC;
      ptr_q       <= '0;
      fetch_valid <= 1'b0;
      fetch_hart  <= '0;
      fetch_pc    <= '0;
      wb_save_pc  <= 1'b0;
      wb_hart     <= '0;
      wb_reg_pc   <= '0;
      redirect    <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_HARTS; i++) begin
        if (ex_valid && take && ex_hart == HART_W'(i))
          pc_q[i] <= tgt_misalign ? TRAP_PC : target;
        else if (sel_found_d && sel_hart_d == HART_W'(i))
          pc_q[i] <= pc_q[i] + 32'd4;
      end
      if (sel_found_d) ptr_q <= sel_hart_d + 1'b1;
      fetch_valid <= sel_found_d;
      fetch_hart  <= sel_found_d ? sel_hart_d : '0;
      fetch_pc    <= sel_found_d ? pc_q[sel_hart_d] : '0;
      wb_save_pc  <= ex_valid && link && !tgt_misalign;
      wb_hart     <= (ex_valid && link && !tgt_misalign) ? ex_hart : '0;
      wb_reg_pc   <= (ex_valid && link && !tgt_misalign) ? link_pc : '0;
      redirect    <= ex_valid && take;
      misalign    <= ex_valid && take && tgt_misalign;
    end
  end

endmodule

// File: tb/tb_rv32_barrel_pc_unit.sv
// Directed bench for rv32_barrel_pc_unit with four harts; PCs are observed through fetch_pc.
module tb_rv32_barrel_pc_unit;
  import rv32_barrel_pc_unit_pkg::*;

  localparam int NH = 4;
  localparam int HW = 2;
  localparam logic [31:0] TRAP = 32'h0000_0100;

  logic              clk = 1'b0;
  logic              rst;
  logic [NH-1:0]     hart_en;
  logic              ex_valid;
  logic [HW-1:0]     ex_hart;
  rv32_opcode_enum_t ex_opcode;
  logic [31:0]       ex_pc, ex_rs1, ex_alu_res, ex_imm;
  logic              fetch_valid, wb_save_pc, redirect, misalign;
  logic [HW-1:0]     fetch_hart, wb_hart;
  logic [31:0]       fetch_pc, wb_reg_pc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv32_barrel_pc_unit #(.NUM_HARTS(NH), .RESET_PC(32'h0), .TRAP_PC(TRAP)) dut (
    .clk(clk), .rst(rst), .hart_en(hart_en),
    .ex_valid(ex_valid), .ex_hart(ex_hart), .ex_opcode(ex_opcode),
    .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_alu_res(ex_alu_res), .ex_imm(ex_imm),
    .fetch_valid(fetch_valid), .fetch_hart(fetch_hart), .fetch_pc(fetch_pc),
    .wb_save_pc(wb_save_pc), .wb_hart(wb_hart), .wb_reg_pc(wb_reg_pc),
    .redirect(redirect), .misalign(misalign)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    ex_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic resolve(input rv32_opcode_enum_t op, input logic [HW-1:0] h,
                         input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] alu, input logic [31:0] imm);
    ex_valid = 1'b1; ex_opcode = op; ex_hart = h;
    ex_pc = pc; ex_rs1 = rs1; ex_alu_res = alu; ex_imm = imm;
  endtask

  task automatic test_reset;
    logic [HW-1:0] exp_h [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0]   exp_p [5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd4};
    hart_en = 4'b1111;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({fetch_valid, fetch_hart, fetch_pc, wb_save_pc, wb_hart, wb_reg_pc, redirect, misalign} !== '0) begin
      failures++;
      $display("FAIL reset_outputs fv=%0b fh=%0d fpc=%h wb=%0b wh=%0d wpc=%h rd=%0b mis=%0b required all zero",
               fetch_valid, fetch_hart, fetch_pc, wb_save_pc, wb_hart, wb_reg_pc, redirect, misalign);
    end
    $display("reset: outputs fv=%0b fpc=%h", fetch_valid, fetch_pc);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (fetch_valid !== 1'b1 || fetch_hart !== exp_h[i] || fetch_pc !== exp_p[i]) begin
        failures++;
        $display("FAIL rr_all[%0d] got v=%0b h=%0d pc=%h required v=1 h=%0d pc=%h",
                 i, fetch_valid, fetch_hart, fetch_pc, exp_h[i], exp_p[i]);
      end
      $display("rr_all[%0d]: hart=%0d pc=%h", i, fetch_hart, fetch_pc);
    end
  endtask

  task automatic test_hart_mask;
    logic [HW-1:0] exp_h [6] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
    logic [31:0]   exp_p [6] = '{32'd0, 32'd0, 32'd4, 32'd4, 32'd8, 32'd8};
    do_reset();
    hart_en = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        hart_en = 4'b0000;
        tick();
        checks++;
        if (fetch_valid !== 1'b0) begin
          failures++;
          $display("FAIL mask_idle got fetch_valid=%0b required 0", fetch_valid);
        end
        $display("mask_idle: fetch_valid=%0b", fetch_valid);
        hart_en = 4'b0101;
      end
      tick();
      checks++;
      if (fetch_valid !== 1'b1 || fetch_hart !== exp_h[i] || fetch_pc !== exp_p[i]) begin
        failures++;
        $display("FAIL mask[%0d] got v=%0b h=%0d pc=%h required v=1 h=%0d pc=%h",
                 i, fetch_valid, fetch_hart, fetch_pc, exp_h[i], exp_p[i]);
      end
      $display("mask[%0d]: hart=%0d pc=%h", i, fetch_hart, fetch_pc);
    end
  endtask

  task automatic test_branch;
    do_reset();
    hart_en = 4'b0000;
    resolve(OP_BEQ, 2'd1, 32'h40, 32'h0, 32'h1, 32'hFFFF_FFF8);
    tick();
    ex_valid = 1'b0;
    checks++;
    if (redirect !== 1'b1 || misalign !== 1'b0 || wb_save_pc !== 1'b0) begin
      failures++;
      $display("FAIL beq_taken got rd=%0b mis=%0b wb=%0b required 1 0 0", redirect, misalign, wb_save_pc);
    end
    $display("beq_taken: redirect=%0b", redirect);
    hart_en = 4'b0010;
    tick();
    checks++;
    if (fetch_hart !== 2'd1 || fetch_pc !== 32'h38) begin
      failures++;
      $display("FAIL beq_pc got h=%0d pc=%h required h=1 pc=00000038", fetch_hart, fetch_pc);
    end
    $display("beq_pc: pc=%h", fetch_pc);
    hart_en = 4'b0000;
    resolve(OP_BEQ, 2'd1, 32'h40, 32'h0, 32'h0, 32'hFFFF_FFF8);
    tick();
    ex_valid = 1'b0;
    checks++;
    if (redirect !== 1'b0 || wb_save_pc !== 1'b0) begin
      failures++;
      $display("FAIL beq_not_taken got rd=%0b wb=%0b required 0 0", redirect, wb_save_pc);
    end
    $display("beq_not_taken: redirect=%0b", redirect);
    hart_en = 4'b0010;
    tick();
    checks++;
    if (fetch_pc !== 32'h3C) begin
      failures++;
      $display("FAIL beq_nt_pc got pc=%h required 0000003c", fetch_pc);
    end
    $display("beq_nt_pc: pc=%h", fetch_pc);
    hart_en = 4'b0000;
    resolve(OP_BGEU, 2'd0, 32'hFFFF_FFF0, 32'h0, 32'h1, 32'h20);
    tick();
    ex_valid = 1'b0;
    hart_en = 4'b0001;
    tick();
    checks++;
    if (redirect !== 1'b0 || fetch_pc !== 32'h10) begin
      failures++;
      $display("FAIL bgeu_wrap got rd=%0b pc=%h required rd=0 pc=00000010", redirect, fetch_pc);
    end
    $display("bgeu_wrap: pc=%h", fetch_pc);
  endtask

  task automatic test_jalr;
    do_reset();
    hart_en = 4'b0000;
    resolve(OP_JALR, 2'd2, 32'h200, 32'h1001, 32'h0, 32'h4);
    tick();
    ex_valid = 1'b0;
    checks++;
    if (redirect !== 1'b1 || misalign !== 1'b0 || wb_save_pc !== 1'b1 || wb_hart !== 2'd2 || wb_reg_pc !== 32'h204) begin
      failures++;
      $display("FAIL jalr_wb got rd=%0b mis=%0b wb=%0b wh=%0d wpc=%h required 1 0 1 2 00000204",
               redirect, misalign, wb_save_pc, wb_hart, wb_reg_pc);
    end
    $display("jalr_wb: wb_reg_pc=%h", wb_reg_pc);
    hart_en = 4'b0100;
    tick();
    checks++;
    if (fetch_hart !== 2'd2 || fetch_pc !== 32'h1004) begin
      failures++;
      $display("FAIL jalr_pc got h=%0d pc=%h required h=2 pc=00001004", fetch_hart, fetch_pc);
    end
    $display("jalr_pc: pc=%h", fetch_pc);
    hart_en = 4'b0000;
    resolve(OP_JALR, 2'd2, 32'h300, 32'h1002, 32'h0, 32'h0);
    tick();
    ex_valid = 1'b0;
    checks++;
    if (misalign !== 1'b1 || redirect !== 1'b1 || wb_save_pc !== 1'b0 || wb_reg_pc !== 32'h0) begin
      failures++;
      $display("FAIL jalr_mis got mis=%0b rd=%0b wb=%0b wpc=%h required 1 1 0 0",
               misalign, redirect, wb_save_pc, wb_reg_pc);
    end
    $display("jalr_mis: misalign=%0b", misalign);
  endtask

  task automatic test_jal_misalign;
    do_reset();
    hart_en = 4'b0000;
    resolve(OP_JAL, 2'd0, 32'h40, 32'h0, 32'h0, 32'h2);
    tick();
    ex_valid = 1'b0;
    checks++;
    if (misalign !== 1'b1 || redirect !== 1'b1 || wb_save_pc !== 1'b0 || wb_reg_pc !== 32'h0) begin
      failures++;
      $display("FAIL jal_mis got mis=%0b rd=%0b wb=%0b wpc=%h required 1 1 0 0",
               misalign, redirect, wb_save_pc, wb_reg_pc);
    end
    $display("jal_mis: misalign=%0b", misalign);
    hart_en = 4'b0001;
    tick();
    checks++;
    if (fetch_pc !== TRAP) begin
      failures++;
      $display("FAIL jal_trap_pc got pc=%h required %h", fetch_pc, TRAP);
    end
    $display("jal_trap_pc: pc=%h", fetch_pc);
  endtask

  task automatic test_auipc;
    do_reset();
    hart_en = 4'b0000;
    resolve(OP_AUIPC, 2'd3, 32'h1000, 32'h0, 32'h1, 32'h1234_5000);
    tick();
    checks++;
    if (wb_save_pc !== 1'b1 || wb_hart !== 2'd3 || wb_reg_pc !== 32'h1234_6000 || redirect !== 1'b0) begin
      failures++;
      $display("FAIL auipc got wb=%0b wh=%0d wpc=%h rd=%0b required 1 3 12346000 0",
               wb_save_pc, wb_hart, wb_reg_pc, redirect);
    end
    $display("auipc: wb_reg_pc=%h", wb_reg_pc);
    resolve(OP_ALU, 2'd3, 32'h1000, 32'h0, 32'h1, 32'h1234_5000);
    tick();
    ex_valid = 1'b0;
    checks++;
    if (wb_save_pc !== 1'b0 || wb_reg_pc !== 32'h0 || redirect !== 1'b0 || misalign !== 1'b0) begin
      failures++;
      $display("FAIL other_op got wb=%0b wpc=%h rd=%0b mis=%0b required 0 0 0 0",
               wb_save_pc, wb_reg_pc, redirect, misalign);
    end
    $display("other_op: wb=%0b", wb_save_pc);
    hart_en = 4'b1000;
    tick();
    checks++;
    if (fetch_hart !== 2'd3 || fetch_pc !== 32'h0) begin
      failures++;
      $display("FAIL auipc_pc got h=%0d pc=%h required h=3 pc=00000000", fetch_hart, fetch_pc);
    end
    $display("auipc_pc: pc=%h", fetch_pc);
  endtask

  task automatic test_back_to_back;
    do_reset();
    hart_en = 4'b1000;
    resolve(OP_JAL, 2'd3, 32'h80, 32'h0, 32'h0, 32'h20);
    tick();
    ex_valid = 1'b0;
    checks++;
    if (fetch_hart !== 2'd3 || fetch_pc !== 32'h0 || redirect !== 1'b1 || wb_reg_pc !== 32'h84) begin
      failures++;
      $display("FAIL collide_cycle got h=%0d pc=%h rd=%0b wpc=%h required 3 0 1 00000084",
               fetch_hart, fetch_pc, redirect, wb_reg_pc);
    end
    $display("collide_cycle: pc=%h", fetch_pc);
    tick();
    checks++;
    if (fetch_pc !== 32'hA0) begin
      failures++;
      $display("FAIL collide_pc got pc=%h required 000000a0", fetch_pc);
    end
    $display("collide_pc: pc=%h", fetch_pc);
  endtask

  task automatic test_reset_midflight;
    do_reset();
    hart_en = 4'b1111;
    tick();
    resolve(OP_JAL, 2'd1, 32'h0, 32'h0, 32'h0, 32'h40);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (fetch_valid !== 1'b0 || fetch_pc !== 32'h0) begin
      failures++;
      $display("FAIL async_reset got fv=%0b pc=%h required 0 0", fetch_valid, fetch_pc);
    end
    $display("async_reset: fetch_valid=%0b", fetch_valid);
    tick();
    rst = 1'b0;
    ex_valid = 1'b0;
    hart_en = 4'b0110;
    tick();
    checks++;
    if (fetch_valid !== 1'b1 || fetch_hart !== 2'd1 || fetch_pc !== 32'h0 || redirect !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got v=%0b h=%0d pc=%h rd=%0b required 1 1 0 0",
               fetch_valid, fetch_hart, fetch_pc, redirect);
    end
    $display("post_reset: hart=%0d pc=%h", fetch_hart, fetch_pc);
  endtask

  initial begin
    rst = 1'b1; hart_en = '0; ex_valid = 1'b0; ex_hart = '0; ex_opcode = OP_NONE;
    ex_pc = '0; ex_rs1 = '0; ex_alu_res = '0; ex_imm = '0;
    test_reset();
    test_hart_mask();
    test_branch();
    test_jalr();
    test_jal_misalign();
    test_auipc();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
